// File: rtl/sc_counter_modn.sv
// Modulo-N up/down event counter with programmable terminal value, parallel load,
// synchronous clear, wrap-or-saturate limits and a registered wrap pulse.
module sc_counter_modn #(
  parameter int COUNTER_DATAWIDTH_BUS = 5,
  parameter bit COUNTER_WRAP_MODE     = 1'b1
) (
  input  logic                             SC_COUNTER_CLOCK_50,
  input  logic                             SC_COUNTER_RESET_InLow,
  input  logic                             SC_COUNTER_clear_InLow,
  input  logic                             SC_COUNTER_load_InLow,
  input  logic [COUNTER_DATAWIDTH_BUS-1:0] SC_COUNTER_data_InBus,
  input  logic [COUNTER_DATAWIDTH_BUS-1:0] SC_COUNTER_terminal_InBus,
  input  logic                             SC_COUNTER_count_InLow,
  input  logic                             SC_COUNTER_up_In,
  output logic [COUNTER_DATAWIDTH_BUS-1:0] SC_COUNTER_regcount_OutBus,
  output logic                             SC_COUNTER_eoc_OutLow,
  output logic                             SC_COUNTER_wrap_OutLow
);

  localparam int W = COUNTER_DATAWIDTH_BUS;

  logic [W-1:0] count_q, count_d;
  logic         wrapEvent_q, wrapEvent_d;

  // Priority clear > load > count > hold; only a real limit crossing in wrap mode
  // raises the wrap event, saturation simply holds the register.
  always_comb begin
    count_d     = count_q;
    wrapEvent_d = 1'b0;
    if (!SC_COUNTER_clear_InLow) begin
      count_d = '0;
    end else if (!SC_COUNTER_load_InLow) begin
      count_d = SC_COUNTER_data_InBus;
    end else if (!SC_COUNTER_count_InLow) begin
      if (SC_COUNTER_up_In) begin
        if (count_q < SC_COUNTER_terminal_InBus) begin
          count_d = count_q + 1'b1;
        end else if (COUNTER_WRAP_MODE) begin
          count_d     = '0;
          wrapEvent_d = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (COUNTER_WRAP_MODE) begin
          count_d     = SC_COUNTER_terminal_InBus;
          wrapEvent_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      count_q     <= '0;
      wrapEvent_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wrapEvent_q <= wrapEvent_d;
    end
  end

  assign SC_COUNTER_regcount_OutBus = count_q;
  assign SC_COUNTER_eoc_OutLow      = (count_q != SC_COUNTER_terminal_InBus);
  assign SC_COUNTER_wrap_OutLow     = ~wrapEvent_q;

endmodule
